// File: rtl/instr_fetch_unit.sv
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Multicycle instruction fetch stage. Accepts a fetch request
//                at the current PC and runs a req/ready read handshake with
//                instruction memory. The returned word is captured into the
//                instruction register. Completion, misalignment and timeout
//                are reported back to the control FSM.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int WORD_SIZE = 32,
  parameter int MAX_WAIT  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  // control FSM side
  input  logic                 fetch_start,
  input  logic [WORD_SIZE-1:0] current_pc,
  // instruction memory side
  output logic                 imem_req,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic                 imem_ready,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  // instruction register and status
  output logic [WORD_SIZE-1:0] ir_out,
  output logic                 ir_valid,
  output logic                 fetch_busy,
  output logic                 fetch_done,
  output logic                 fetch_err
);

  // The wait counter only has to reach MAX_WAIT-1; one spare bit keeps
  // the width non-zero for MAX_WAIT=1 and guarantees it never wraps.
  localparam int CW = $clog2(MAX_WAIT) + 1;

  // Terminal count: the last permitted cycle of waiting for imem_ready.
  localparam logic [CW-1:0] C_WAIT_LAST = CW'(MAX_WAIT - 1);

  // Low address bits that must be zero for a word-aligned fetch.
  localparam int C_ALIGN_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        wait_cnt_q;
  logic                 req_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] ir_q;
  logic                 ir_valid_q;
  logic                 done_q;
  logic                 err_q;

  // Misalignment is judged on the PC presented with the start pulse.
  logic                 pc_misaligned_w;
  // The memory answered during an outstanding request.
  logic                 rsp_hit_w;
  // No answer and the waiting budget is used up.
  logic                 wait_expired_w;

  // Decode the conditions used by the sequencer below.
  always_comb begin
    pc_misaligned_w = |current_pc[C_ALIGN_BITS-1:0];
    rsp_hit_w       = req_q & imem_ready;
    wait_expired_w  = (wait_cnt_q == C_WAIT_LAST);
  end

  // Fetch sequencer: state and every registered output in one place so that
  // all outputs change together on the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (fetch_start) begin
            // A new accepted request discards the previous outcome.
            err_q      <= 1'b0;
            ir_valid_q <= 1'b0;
            if (pc_misaligned_w) begin
              // Never touch memory for a misaligned PC; report straight away.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              addr_q     <= current_pc;
              req_q      <= 1'b1;
              wait_cnt_q <= '0;
              state_q    <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          // Address and request stay untouched until the handshake ends.
          if (rsp_hit_w) begin
            ir_q       <= imem_rdata;
            ir_valid_q <= 1'b1;
            req_q      <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end else if (wait_expired_w) begin
            // Give up: the IR keeps whatever it held before this fetch.
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end

        ST_DONE: begin
          // Completion pulse lasts one cycle; starts seen here are dropped.
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          // Unreachable encoding: recover to a quiet idle state.
          req_q   <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Drive the ports from the registered state.
  always_comb begin
    imem_req   = req_q;
    imem_addr  = addr_q;
    ir_out     = ir_q;
    ir_valid   = ir_valid_q;
    fetch_done = done_q;
    fetch_err  = err_q;
    fetch_busy = (state_q != ST_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Scoreboard bench for instr_fetch_unit. The driver computes
//                the outcome of each fetch from the fetch rules (alignment,
//                ready delay versus MAX_WAIT) and queues it; the monitor
//                checks every request cycle and every completion pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam int WS = 32;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_start;
  logic [WS-1:0] current_pc;
  logic          imem_req;
  logic [WS-1:0] imem_addr;
  logic          imem_ready;
  logic [WS-1:0] imem_rdata;
  logic [WS-1:0] ir_out;
  logic          ir_valid;
  logic          fetch_busy;
  logic          fetch_done;
  logic          fetch_err;

  instr_fetch_unit #(.WORD_SIZE(WS), .MAX_WAIT(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_start(fetch_start),
    .current_pc (current_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .ir_out     (ir_out),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WS-1:0] addr;
    int            req_cycles;
    logic          err;
    logic [WS-1:0] ir;
    logic          valid;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  logic [WS-1:0] model_ir = '0;

  task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference outcome: a fetch either faults on alignment, completes when
  // ready arrives within MAX_WAIT request cycles, or times out after MAX_WAIT.
  task automatic do_fetch(input logic [WS-1:0] pc, input int delay,
                          input logic [WS-1:0] data, input bit repulse);
    exp_t e;
    int   n_req;
    e.addr = pc;
    if (pc[1:0] != 2'b00) begin
      n_req = 0; e.err = 1'b1; e.valid = 1'b0; e.ir = model_ir;
    end else if (delay < MW) begin
      n_req = delay + 1; e.err = 1'b0; e.valid = 1'b1; e.ir = data;
      model_ir = data;
    end else begin
      n_req = MW; e.err = 1'b1; e.valid = 1'b0; e.ir = model_ir;
    end
    e.req_cycles = n_req;
    sb.push_back(e);
    fetch_start = 1'b1;
    current_pc  = pc;
    tick();
    fetch_start = 1'b0;
    current_pc  = $urandom;
    for (int k = 0; k < n_req; k++) begin
      imem_ready  = (k == delay);
      imem_rdata  = (k == delay) ? data : $urandom;
      fetch_start = repulse ? 1'($urandom_range(0, 1)) : 1'b0;
      current_pc  = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    // DONE cycle: a stray ready and a re-pulsed start must both be ignored.
    imem_ready  = 1'($urandom_range(0, 1));
    imem_rdata  = $urandom;
    fetch_start = repulse;
    current_pc  = $urandom & 32'hFFFF_FFFC;
    tick();
    fetch_start = 1'b0;
    // One idle cycle, possibly with a spurious ready.
    imem_ready  = 1'($urandom_range(0, 1));
    imem_rdata  = $urandom;
    tick();
    imem_ready  = 1'b0;
  endtask

  // Monitor: checks request cycles against the pending fetch, completion
  // pulses against the queued outcome, and held values while idle.
  int            req_cnt = 0;
  int            busy_cnt = 0;
  logic          prev_done = 1'b0;
  logic [WS-1:0] last_ir = '0;
  logic          last_valid = 1'b0;
  logic          last_err = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      req_cnt = 0; busy_cnt = 0; prev_done = 1'b0;
      last_ir = '0; last_valid = 1'b0; last_err = 1'b0;
    end else begin
      if (fetch_busy) busy_cnt++;
      if (prev_done) chk("busy_after_done", {31'd0, fetch_busy}, 32'd0);
      if (imem_req) begin
        req_cnt++;
        if (sb.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
        else                chk("req_addr", imem_addr, sb[0].addr);
      end
      if (fetch_done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_err",      {31'd0, fetch_err}, {31'd0, e.err});
          chk("done_ir",       ir_out, e.ir);
          chk("done_valid",    {31'd0, ir_valid}, {31'd0, e.valid});
          chk("done_req_cyc",  req_cnt, e.req_cycles);
          chk("done_latency",  busy_cnt, e.req_cycles + 1);
          chk("done_req_low",  {31'd0, imem_req}, 32'd0);
          last_ir = e.ir; last_valid = e.valid; last_err = e.err;
        end
        req_cnt = 0; busy_cnt = 0;
      end else if (!fetch_busy) begin
        chk("idle_ir",    ir_out, last_ir);
        chk("idle_valid", {31'd0, ir_valid}, {31'd0, last_valid});
        chk("idle_err",   {31'd0, fetch_err}, {31'd0, last_err});
        chk("idle_req",   {31'd0, imem_req}, 32'd0);
      end
      prev_done = fetch_done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ir"},    ir_out, 32'd0);
    chk({tag, "_valid"}, {31'd0, ir_valid}, 32'd0);
    chk({tag, "_err"},   {31'd0, fetch_err}, 32'd0);
    chk({tag, "_done"},  {31'd0, fetch_done}, 32'd0);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"},  imem_addr, 32'd0);
    chk({tag, "_busy"},  {31'd0, fetch_busy}, 32'd0);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; fetch_start = 1'b0; current_pc = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    #12;
    chk_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // Directed cases from the fetch rules.
    do_fetch(32'h0000_0040, 0,   32'h0050_0093, 1'b0);
    do_fetch(32'h0000_0100, 4,   32'hFE00_0EE3, 1'b0);
    do_fetch(32'h0000_0042, 0,   32'hDEAD_BEEF, 1'b0);
    do_fetch(32'h0000_0044, 1,   32'h1234_5678, 1'b0);
    do_fetch(32'h0000_0048, 100, 32'hBAD0_BAD0, 1'b0);
    do_fetch(32'h0000_004C, MW-1, 32'hCAFE_F00D, 1'b0);
    do_fetch(32'h0000_0050, 2,   32'h0BAD_C0DE, 1'b1);
    do_fetch(32'h0000_0053, 0,   32'h0,         1'b1);

    // Asynchronous reset in the middle of a request.
    e.addr = 32'h0000_0080; e.req_cycles = 0; e.err = 1'b0; e.ir = '0; e.valid = 1'b0;
    sb.push_back(e);
    fetch_start = 1'b1; current_pc = 32'h0000_0080;
    tick();
    fetch_start = 1'b0;
    tick(); tick();
    #2;
    reset = 1'b1;
    sb.delete();
    model_ir = '0;
    #1;
    chk_all_zero("async_rst");
    tick();
    reset = 1'b0;
    tick();
    do_fetch(32'h0000_0084, 3, 32'h00A0_0513, 1'b0);

    // Randomised fetches.
    for (int i = 0; i < 40; i++) begin
      logic [WS-1:0] pc;
      pc = $urandom;
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      do_fetch(pc, int'($urandom_range(0, 20)), $urandom, 1'($urandom_range(0, 1)));
    end

    tick(); tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multicycle fetch stage directly downstream of the PC register.
- Takes `current_pc` when the control FSM pulses `fetch_start` in its IF state.
- Runs a request/ready read handshake with instruction memory and captures the returned word into the instruction register (IR).
- Reports completion, misalignment or timeout back to control.

Parameters:
- WORD_SIZE, 32, width of PC, address and instruction word.
- MAX_WAIT, 15, maximum cycles `imem_req` stays high without `imem_ready` before the fetch times out (minimum 1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_start`  in  1  one-cycle request from the control FSM to fetch at `current_pc`.
- `current_pc`  in  WORD_SIZE  PC register output.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  WORD_SIZE  read address, stable while `imem_req`=1.
- `imem_ready`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  WORD_SIZE  read data.
- `ir_out`  out  WORD_SIZE  instruction register.
- `ir_valid`  out  1  `ir_out` holds a successfully fetched word.
- `fetch_busy`  out  1  a fetch is in progress (state ≠ IDLE).
- `fetch_done`  out  1  one-cycle completion pulse (success or error).
- `fetch_err`  out  1  last fetch failed; sticky until the next accepted `fetch_start`.

Behaviour:
- Reset (async, active-high), takes effect immediately, including mid-fetch:
  - state=IDLE.
  - `ir_out`=0, `ir_valid`=0, `fetch_err`=0, `fetch_done`=0, `imem_req`=0, `imem_addr`=0.
  - Wait counter=0.
- States: IDLE, REQ, DONE. All registered outputs change only on `clk` rising edges except under reset.
- IDLE:
  - On `fetch_start`=1 the request is accepted: `fetch_err` clears and `ir_valid` clears.
  - If `current_pc`[1:0]≠0 (misaligned): `fetch_err`←1, go to DONE, no memory request issued, `ir_out` unchanged.
  - Otherwise: `imem_addr`←`current_pc`, `imem_req`←1, wait counter←0, go to REQ.
- REQ:
  - `imem_req` held at 1 and `imem_addr` held constant.
  - If `imem_ready`=1: `ir_out`←`imem_rdata`, `ir_valid`←1, `imem_req`←0, go to DONE.
  - Else if wait counter = MAX_WAIT−1: `imem_req`←0, `fetch_err`←1, go to DONE, `ir_out` unchanged.
  - Else wait counter increments.
- DONE: `fetch_done`=1 for exactly this one cycle, then unconditionally go to IDLE.
- `fetch_start` while state≠IDLE is ignored; it is not queued.
- `imem_ready` while `imem_req`=0 is ignored, so late or spurious readies never alter `ir_out`.
- Latency:
  - `fetch_start` at cycle 0, `imem_req` high from cycle 1.
  - With `imem_ready` at cycle 1, `ir_out` is valid from cycle 2 and `fetch_done` is high in cycle 2.
  - Each additional ready-wait cycle adds 1.
  - Misaligned fetch: `fetch_done` in cycle 1.
  - Timeout: `imem_req` high for exactly MAX_WAIT cycles, `fetch_done` the cycle after the last.
- `ir_out` holds its value between fetches; the control FSM reads it in ID and later states.
- `fetch_busy` = (state≠IDLE), decoded from registered state.
- Wait counter width: clog2(MAX_WAIT)+1 bits; it never wraps.

Test Plan:
- Reset asserted asynchronously mid-REQ (between clock edges) → all outputs 0 immediately, state IDLE; a subsequent `fetch_start` works normally.
- `current_pc`=0x0000_0040, `fetch_start` at cycle 0, `imem_ready`=1 with `imem_rdata`=0x0050_0093 at cycle 1 → `imem_req`=1 and `imem_addr`=0x40 in cycle 1; `ir_out`=0x0050_0093, `ir_valid`=1, `fetch_done`=1 in cycle 2; `fetch_busy`=0 in cycle 3.
- Ready delayed 4 cycles with `imem_rdata`=0xFE00_0EE3 → `imem_addr` stable for 5 request cycles; `fetch_done` one cycle after ready; `ir_out`=0xFE00_0EE3; `fetch_err`=0.
- `current_pc`=0x0000_0042 → no `imem_req`; `fetch_done` and `fetch_err`=1 at cycle 1; `ir_out` keeps the previous value; next aligned fetch clears `fetch_err`.
- `imem_ready` never asserted, MAX_WAIT=15 → `imem_req` high exactly 15 cycles, then `fetch_done` with `fetch_err`=1; a ready pulse arriving afterwards does not change `ir_out`.
- `fetch_start` re-pulsed during REQ and during DONE → ignored; exactly one `imem_req` burst and one `fetch_done` pulse per accepted start.
